pci_wfifo_arbiter: RTL and testbench
====================================

PCI_WFIFO_ARBITER -- requirements
Module: pci_wfifo_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of system-side requesters sharing the PCI write-FIFO push port.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Parameter LW, default 4, burst-length field width; a field value of N means N+1 words.
REQ-004 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NREQ  per-requester burst request; level, held until burst_done for that requester.
REQ-007 burst_len  input  NREQ*LW  per-requester length field; requester i occupies bits [i*LW +: LW].
REQ-008 req_data  input  NREQ*DW  per-requester current word; requester i occupies bits [i*DW +: DW]; requester advances on its data_ack.
REQ-009 wfifo_full  input  1  PCI write FIFO full; no push is allowed while it is high.
REQ-010 gnt  output  NREQ  one-hot grant, registered.
REQ-011 data_ack  output  NREQ  per-requester word-accepted strobe, equal to gnt AND wfifo_push.
REQ-012 wfifo_push  output  1  push strobe to the PCI write FIFO.
REQ-013 pci_write_data  output  DW  word muxed from the granted requester.
REQ-014 burst_done  output  1  single-cycle pulse coincident with the final push of a burst.
REQ-015 busy  output  1  high while in state XFER.

Function
REQ-016 FSM has two states, IDLE and XFER; state, gnt, winner, last_winner and word counter are registered.
REQ-017 IDLE with req nonzero: select the winner round-robin, searching from (last_winner+1) mod NREQ upward with wrap.
REQ-018 In the same IDLE cycle, load gnt with one-hot(winner), load cnt with burst_len of the winner, and transition to XFER; gnt is visible the cycle after req is sampled.
REQ-019 IDLE with req equal to 0: remain in IDLE, gnt=0.
REQ-020 XFER: wfifo_push = ~wfifo_full (combinational); pci_write_data = req_data of the winner.
REQ-021 XFER push with cnt>0: cnt decrements by 1.
REQ-022 XFER push with cnt==0: burst_done=1, last_winner<=winner, gnt<=0, next state IDLE.
REQ-023 XFER with wfifo_full high: no push, no data_ack, cnt and gnt hold; stall length is unbounded.
REQ-024 Bursts are non-preemptible; req changes during XFER are ignored, including deassertion by the granted requester and assertion by others.
REQ-025 At least one IDLE cycle separates consecutive bursts; throughput is (N+1) words per (N+2) cycles when unstalled.
REQ-026 Outside XFER, wfifo_push, data_ack, burst_done and pci_write_data are all 0.
REQ-027 At most one bit of gnt and of data_ack is high in any cycle.
REQ-028 burst_len is sampled only at grant; later changes do not affect the active burst.

Reset
REQ-029 With sys_rst_n low at a rising edge: state=IDLE, gnt=0, cnt=0, last_winner=NREQ-1 (requester 0 has first priority), busy=0, and all combinational outputs are 0 in the following cycle.
REQ-030 Reset asserted mid-burst aborts the burst with no further push and no burst_done; the requester observes gnt drop.

Verification
REQ-031 Single requester: req=4'b0001, burst_len[0]=3, wfifo_full=0 -> gnt=0001 one cycle later; 4 consecutive pushes; burst_done on the 4th; gnt=0 the following cycle.
REQ-032 All request: req=4'b1111, all lengths 0, held -> grant order 0,1,2,3,0, each burst is 1 push followed by 1 IDLE cycle.
REQ-033 Stall: burst_len=2 with wfifo_full high for 5 cycles after the first push -> exactly 3 pushes total, cnt holds during the stall, burst_done on the 3rd push.
REQ-034 Full at last word: wfifo_full rises on the cycle the final word is due -> no burst_done until wfifo_full falls; then one push with burst_done.
REQ-035 Reset mid-burst: sys_rst_n low during the 2nd word of a 16-word burst -> no push in the cycle after the reset edge, gnt=0, and next grant goes to requester 0 if it is requesting.
REQ-036 Wrap/priority: last_winner=3, req=4'b1010 -> gnt=0010; then with req=4'b1010 still held -> gnt=1000.

Source files
------------

// File: rtl/pci_wfifo_arbiter.sv
// Round-robin arbiter feeding the PCI write FIFO from NREQ system-side
// burst requesters; one non-preemptible burst at a time.

module pci_wfifo_arbiter_lane #(
    parameter int DW = 32
) (
    input  logic          gnt,
    input  logic          push,
    input  logic [DW-1:0] data,
    output logic          ack,
    output logic [DW-1:0] data_q
);
    assign ack    = gnt & push;
    assign data_q = gnt ? data : '0;
endmodule

module pci_wfifo_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int LW   = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LW-1:0]   burst_len,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 wfifo_full,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      data_ack,
    output logic                 wfifo_push,
    output logic [DW-1:0]        pci_write_data,
    output logic                 burst_done,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                    state;
    logic [IW-1:0]             winner, last_winner, next_winner;
    logic                      found;
    logic [LW-1:0]             cnt;
    logic [NREQ-1:0][LW-1:0]   len_arr;
    logic [NREQ-1:0][DW-1:0]   data_arr;
    logic [NREQ-1:0][DW-1:0]   lane_data;

    assign len_arr  = burst_len;
    assign data_arr = req_data;

    // Search starts one past the last winner and wraps, so every requester
    // gets a turn before any one repeats.
    always_comb begin
        int idx;
        idx         = 0;
        found       = 1'b0;
        next_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_winner) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IW'(idx)]) begin
                found       = 1'b1;
                next_winner = IW'(idx);
            end
        end
    end

    assign busy       = (state == XFER);
    assign wfifo_push = busy && !wfifo_full;
    assign burst_done = wfifo_push && (cnt == '0);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            cnt         <= '0;
            winner      <= '0;
            last_winner <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= next_winner;
                        gnt    <= NREQ'(1) << next_winner;
                        cnt    <= len_arr[next_winner];
                        state  <= XFER;
                    end else begin
                        gnt <= '0;
                    end
                end
                XFER: begin
                    if (wfifo_push) begin
                        if (cnt == '0) begin
                            last_winner <= winner;
                            gnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt - LW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // gnt is zero outside XFER, so the lanes also force ack/data to zero there.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        pci_wfifo_arbiter_lane #(.DW(DW)) u_lane (
            .gnt    (gnt[i]),
            .push   (wfifo_push),
            .data   (data_arr[i]),
            .ack    (data_ack[i]),
            .data_q (lane_data[i])
        );
    end

    always_comb begin
        pci_write_data = '0;
        for (int i = 0; i < NREQ; i++) pci_write_data = pci_write_data | lane_data[i];
    end
endmodule

// File: tb/tb_pci_wfifo_arbiter.sv
// Directed vector bench for pci_wfifo_arbiter: per-cycle table plus a
// hand-written per-lane-length burst sequence.

module tb_pci_wfifo_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LW   = 4;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*LW-1:0]   burst_len;
    logic [NREQ*DW-1:0]   req_data;
    logic                 wfifo_full;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      data_ack;
    logic                 wfifo_push;
    logic [DW-1:0]        pci_write_data;
    logic                 burst_done;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    pci_wfifo_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .req            (req),
        .burst_len      (burst_len),
        .req_data       (req_data),
        .wfifo_full     (wfifo_full),
        .gnt            (gnt),
        .data_ack       (data_ack),
        .wfifo_push     (wfifo_push),
        .pci_write_data (pci_write_data),
        .burst_done     (burst_done),
        .busy           (busy)
    );

    typedef struct {
        bit         rst_n;
        logic [3:0] req;
        logic [3:0] len;
        bit         full;
        logic [3:0] gnt;
        bit         push;
        bit         done;
        bit         busy;
    } vec_t;

    vec_t tv[$];

    function automatic logic [DW-1:0] word_of(input int k);
        return 32'hD000_0000 | (32'(k) * 32'h0000_0101);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [3:0] g);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NREQ; k++) if (g[k]) d = word_of(k);
        return d;
    endfunction

    task automatic add(input bit r, input logic [3:0] q, input logic [3:0] l, input bit f,
                       input logic [3:0] g, input bit p, input bit d, input bit b);
        vec_t v;
        v.rst_n = r; v.req = q; v.len = l; v.full = f;
        v.gnt = g; v.push = p; v.done = d; v.busy = b;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        int pushes, first_push, done_at;

        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = word_of(k);
        sys_rst_n  = 1'b0;
        req        = '0;
        burst_len  = '0;
        wfifo_full = 1'b0;

        // single requester, len 3: grant next cycle, 4 pushes, done on 4th
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0001, 4'd3, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0001, 4'd3, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'd3, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'd3, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'd3, 0, 4'b0001, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        // reset, then all requesting with len 0: order 0,1,2,3,0
        add(0, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b0001, 1, 1, 1);
        add(1, 4'b1111, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b0010, 1, 1, 1);
        add(1, 4'b1111, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b0100, 1, 1, 1);
        add(1, 4'b1111, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b1000, 1, 1, 1);
        add(1, 4'b1111, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 4'd0, 0, 4'b0001, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        // make requester 3 the last winner, then req=1010 -> 1 then 3
        add(1, 4'b1000, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1000, 4'd0, 0, 4'b1000, 1, 1, 1);
        add(1, 4'b1010, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1010, 4'd0, 0, 4'b0010, 1, 1, 1);
        add(1, 4'b1010, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1010, 4'd0, 0, 4'b1000, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        // len 2 with 5-cycle stall after first push; len/req wiggles ignored
        add(1, 4'b0001, 4'd2, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0001, 4'd2, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'd15, 1, 4'b0001, 0, 0, 1);
        add(1, 4'b1111, 4'd15, 1, 4'b0001, 0, 0, 1);
        add(1, 4'b0000, 4'd15, 1, 4'b0001, 0, 0, 1);
        add(1, 4'b0110, 4'd15, 1, 4'b0001, 0, 0, 1);
        add(1, 4'b0001, 4'd15, 1, 4'b0001, 0, 0, 1);
        add(1, 4'b0001, 4'd15, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'd15, 0, 4'b0001, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        // full exactly when the last word is due
        add(1, 4'b0010, 4'd1, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0010, 4'd1, 0, 4'b0010, 1, 0, 1);
        add(1, 4'b0010, 4'd1, 1, 4'b0010, 0, 0, 1);
        add(1, 4'b0010, 4'd1, 1, 4'b0010, 0, 0, 1);
        add(1, 4'b0010, 4'd1, 0, 4'b0010, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);
        // reset during 2nd word of a 16-word burst; priority returns to 0
        add(1, 4'b0101, 4'd15, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0101, 4'd15, 0, 4'b0100, 1, 0, 1);
        add(0, 4'b0101, 4'd15, 0, 4'b0100, 1, 0, 1);
        add(1, 4'b0101, 4'd0, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0101, 4'd0, 0, 4'b0001, 1, 1, 1);
        add(1, 4'b0000, 4'd0, 0, 4'b0000, 0, 0, 0);

        repeat (2) @(posedge sys_clk);

        foreach (tv[i]) begin
            @(negedge sys_clk);
            sys_rst_n  = tv[i].rst_n;
            req        = tv[i].req;
            burst_len  = {NREQ{tv[i].len}};
            wfifo_full = tv[i].full;
            #1;
            chk("gnt",        i, 64'(gnt),            64'(tv[i].gnt));
            chk("wfifo_push", i, 64'(wfifo_push),     64'(tv[i].push));
            chk("burst_done", i, 64'(burst_done),     64'(tv[i].done));
            chk("busy",       i, 64'(busy),           64'(tv[i].busy));
            chk("data_ack",   i, 64'(data_ack),       64'(tv[i].push ? tv[i].gnt : 4'b0000));
            chk("write_data", i, 64'(pci_write_data), 64'(exp_data(tv[i].gnt)));
        end

        // per-lane lengths: requester 2 has len 2, the others 7 -> 3 words
        @(negedge sys_clk);
        for (int k = 0; k < NREQ; k++) burst_len[k*LW +: LW] = (k == 2) ? 4'd2 : 4'd7;
        req        = 4'b0100;
        wfifo_full = 1'b0;
        pushes     = 0;
        first_push = -1;
        done_at    = -1;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge sys_clk);
            #1;
            if (wfifo_push) begin
                if (first_push < 0) first_push = c;
                pushes++;
                chk("seq_data", c, 64'(pci_write_data), 64'(word_of(2)));
            end
            if (burst_done) done_at = c;
        end
        req = '0;
        chk("seq_done_seen", 0, 64'(done_at >= 0), 64'(1));
        chk("seq_pushes",    0, 64'(pushes),       64'(3));
        chk("seq_span",      0, 64'(done_at - first_push), 64'(2));
        @(negedge sys_clk);
        #1;
        chk("seq_idle_gnt",  0, 64'(gnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
